// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the rename/reorder-buffer slice.
package cpu_pkg;

    localparam int unsigned PREG_WIDTH = 6;
    localparam int unsigned AREG_WIDTH = 5;
    localparam int unsigned ROB_DEPTH  = 16;
    localparam int unsigned TAG_WIDTH  = $clog2(ROB_DEPTH);

    typedef logic [TAG_WIDTH-1:0]  rob_tag_t;
    typedef logic [TAG_WIDTH:0]    rob_count_t;
    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [AREG_WIDTH-1:0] areg_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        logic  rd_valid;
        areg_t ard;
        preg_t prd;
        preg_t old_prd;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/execute/free-list facing bundle of the reorder buffer.
interface reorder_buffer_if;
    import cpu_pkg::*;

    logic       alloc_valid;
    logic       alloc_rd_valid;
    areg_t      alloc_ard;
    preg_t      alloc_prd;
    preg_t      alloc_old_prd;
    logic       alloc_ready;
    rob_tag_t   alloc_tag;
    logic       cmpl_valid;
    rob_tag_t   cmpl_tag;
    logic       retire_valid;
    areg_t      retire_ard;
    preg_t      retire_prd;
    logic       push_free_reg;
    preg_t      freed_reg;
    rob_count_t count;

    modport master (
        output alloc_valid, alloc_rd_valid, alloc_ard, alloc_prd, alloc_old_prd,
        output cmpl_valid, cmpl_tag,
        input  alloc_ready, alloc_tag, retire_valid, retire_ard, retire_prd,
        input  push_free_reg, freed_reg, count
    );

    modport slave (
        input  alloc_valid, alloc_rd_valid, alloc_ard, alloc_prd, alloc_old_prd,
        input  cmpl_valid, cmpl_tag,
        output alloc_ready, alloc_tag, retire_valid, retire_ard, retire_prd,
        output push_free_reg, freed_reg, count
    );

endinterface

// File: rtl/rob_ptr.sv
// Wrap-around ROB pointer with increment enable.
module rob_ptr
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     inc,
    output rob_tag_t ptr
);

    // Power-of-two depth: natural overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + rob_tag_t'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocate at tail, complete out of order, retire at head
// and hand the superseded physical register back to the free list.
module reorder_buffer
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  bus
);

    rob_entry_t entries [ROB_DEPTH];
    rob_tag_t   head;
    rob_tag_t   tail;
    rob_count_t count_q;
    logic       alloc_ready;
    logic       alloc_fire;
    logic       retire_fire;

    // Full blocks allocation even when the head retires this edge.
    assign alloc_ready = (count_q != rob_count_t'(ROB_DEPTH));
    assign alloc_fire  = bus.alloc_valid && alloc_ready;
    assign retire_fire = entries[head].valid && entries[head].done;

    assign bus.alloc_ready = alloc_ready;
    assign bus.alloc_tag   = tail;
    assign bus.count       = count_q;

    rob_ptr u_head (
        .clk (clk),
        .rst (rst),
        .inc (retire_fire),
        .ptr (head)
    );

    rob_ptr u_tail (
        .clk (clk),
        .rst (rst),
        .inc (alloc_fire),
        .ptr (tail)
    );

    // Completion only marks live entries; the tag being allocated this edge is not yet live.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (bus.cmpl_valid && entries[bus.cmpl_tag].valid) begin
                entries[bus.cmpl_tag].done <= 1'b1;
            end
            if (retire_fire) begin
                entries[head].valid <= 1'b0;
            end
            if (alloc_fire) begin
                entries[tail] <= '{valid:    1'b1,
                                   done:     1'b0,
                                   rd_valid: bus.alloc_rd_valid,
                                   ard:      bus.alloc_ard,
                                   prd:      bus.alloc_prd,
                                   old_prd:  bus.alloc_old_prd};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (alloc_fire && !retire_fire) begin
            count_q <= count_q + rob_count_t'(1);
        end else if (!alloc_fire && retire_fire) begin
            count_q <= count_q - rob_count_t'(1);
        end
    end

    // Retire and free-list outputs pulse for one cycle and load zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.retire_valid  <= 1'b0;
            bus.retire_ard    <= '0;
            bus.retire_prd    <= '0;
            bus.push_free_reg <= 1'b0;
            bus.freed_reg     <= '0;
        end else begin
            bus.retire_valid  <= retire_fire;
            bus.retire_ard    <= retire_fire ? entries[head].ard : '0;
            bus.retire_prd    <= retire_fire ? entries[head].prd : '0;
            bus.push_free_reg <= retire_fire && entries[head].rd_valid;
            bus.freed_reg     <= (retire_fire && entries[head].rd_valid) ?
                                 entries[head].old_prd : '0;
        end
    end

endmodule
